uart_receiver: RTL and testbench

Serial-to-parallel UART receive stage: consumes the 8N1 line driven by the team's UART transmitter (or an external host). It recovers bytes LSB-first using a fixed clock-per-bit count and mid-bit sampling, and presents each byte with a one-cycle valid strobe. Stop-bit violations are flagged. The block sits between the board RX pin and any byte consumer (display, FIFO, loopback to the transmitter).

---
 rtl/uart_pkg.sv | 15 +
 rtl/uart_rx_sync.sv | 26 ++
 rtl/uart_receiver.sv | 133 +++++++++++++
 tb/tb_uart_receiver.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared UART definitions: FSM state encoding (common with the transmitter) and frame constants.
package uart_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        START   = 3'd1,
        DATA    = 3'd2,
        STOP    = 3'd3,
        CLEANUP = 3'd4
    } uart_state_e;

    localparam int DEFAULT_CLKS_PER_BIT = 868;
    localparam int DATA_BITS            = 8;

endpackage

// File: rtl/uart_rx_sync.sv
// Two-flop synchronizer for asynchronous single-bit inputs (RX pin, buttons).
module uart_rx_sync #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk_i,
    input  logic reset_i,
    input  logic d_i,
    output logic q_o
);

    logic r_meta;
    logic r_sync;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
        end else begin
            r_meta <= d_i;
            r_sync <= r_meta;
        end
    end

    assign q_o = r_sync;

endmodule

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: start-edge aligned bit counter, mid-bit sampling, LSB first,
// one-cycle valid / framing-error strobes.
//   state   | meaning
//   IDLE    | line idle, waiting for a low rx_s
//   START   | counting to mid start bit to confirm it
//   DATA    | sampling 8 data bits, one per bit period
//   STOP    | sampling the stop bit, publishing byte or error
//   CLEANUP | waiting for the line to return high
module uart_receiver
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clk_i,
    input  logic       reset_i,
    input  logic       rx_i,
    output logic [7:0] data_o,
    output logic       valid_o,
    output logic       framing_err_o,
    output logic       active_f
);

    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam int BW = $clog2(DATA_BITS);
    localparam logic [CW-1:0] HALF     = CW'((CLKS_PER_BIT - 1) / 2);
    localparam logic [CW-1:0] LAST     = CW'(CLKS_PER_BIT - 1);
    localparam logic [BW-1:0] LAST_BIT = BW'(DATA_BITS - 1);

    logic                 w_rx_s;
    uart_state_e          r_state, w_state_nx;
    logic [CW-1:0]        r_cnt, w_cnt_nx;
    logic [BW-1:0]        r_bit_idx, w_bit_idx_nx;
    logic [DATA_BITS-1:0] r_shift, w_shift_nx;
    logic [7:0]           r_data, w_data_nx;
    logic                 r_valid, w_valid_nx;
    logic                 r_err, w_err_nx;
    logic                 r_active, w_active_nx;

    uart_rx_sync #(.RESET_VAL(1'b1)) u_sync (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .d_i     (rx_i),
        .q_o     (w_rx_s)
    );

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_bit_idx <= '0;
            r_shift   <= '0;
            r_data    <= 8'h00;
            r_valid   <= 1'b0;
            r_err     <= 1'b0;
            r_active  <= 1'b0;
        end else begin
            r_state   <= w_state_nx;
            r_cnt     <= w_cnt_nx;
            r_bit_idx <= w_bit_idx_nx;
            r_shift   <= w_shift_nx;
            r_data    <= w_data_nx;
            r_valid   <= w_valid_nx;
            r_err     <= w_err_nx;
            r_active  <= w_active_nx;
        end
    end

    always_comb begin
        w_state_nx   = r_state;
        w_cnt_nx     = r_cnt;
        w_bit_idx_nx = r_bit_idx;
        w_shift_nx   = r_shift;
        w_data_nx    = r_data;
        w_valid_nx   = 1'b0;
        w_err_nx     = 1'b0;
        w_active_nx  = (r_state == START) || (r_state == DATA) || (r_state == STOP);
        case (r_state)
            IDLE: begin
                w_cnt_nx     = '0;
                w_bit_idx_nx = '0;
                if (!w_rx_s) w_state_nx = START;
            end
            START: begin
                if (r_cnt == HALF) begin
                    w_cnt_nx   = '0;
                    w_state_nx = w_rx_s ? IDLE : DATA;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            DATA: begin
                if (r_cnt == LAST) begin
                    w_cnt_nx              = '0;
                    w_shift_nx[r_bit_idx] = w_rx_s;
                    if (r_bit_idx == LAST_BIT) w_state_nx = STOP;
                    else                       w_bit_idx_nx = r_bit_idx + 1'b1;
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            STOP: begin
                if (r_cnt == LAST) begin
                    w_cnt_nx   = '0;
                    w_state_nx = CLEANUP;
                    if (w_rx_s) begin
                        w_data_nx  = r_shift;
                        w_valid_nx = 1'b1;
                    end else begin
                        w_err_nx = 1'b1;
                    end
                end else begin
                    w_cnt_nx = r_cnt + 1'b1;
                end
            end
            // A held-low break stays here, so it reports a single framing error.
            CLEANUP: begin
                w_cnt_nx = '0;
                if (w_rx_s) w_state_nx = IDLE;
            end
            default: begin
                w_state_nx   = IDLE;
                w_cnt_nx     = '0;
                w_bit_idx_nx = '0;
            end
        endcase
    end

    assign data_o        = r_data;
    assign valid_o       = r_valid;
    assign framing_err_o = r_err;
    assign active_f      = r_active;

endmodule

// File: tb/tb_uart_receiver.sv
// Self-checking bench for uart_receiver at 16 clocks per bit: directed frame table,
// hand-written corner sequences, and randomized frames against a frame-level model.
module tb_uart_receiver;

    localparam int CPB  = 16;
    localparam int HALF = (CPB - 1) / 2;
    localparam int LAT  = 3 + HALF + 9 * CPB;

    logic       clk_i = 1'b0;
    logic       reset_i;
    logic       rx_i;
    logic [7:0] data_o;
    logic       valid_o;
    logic       framing_err_o;
    logic       active_f;

    uart_receiver #(.CLKS_PER_BIT(CPB)) dut (
        .clk_i         (clk_i),
        .reset_i       (reset_i),
        .rx_i          (rx_i),
        .data_o        (data_o),
        .valid_o       (valid_o),
        .framing_err_o (framing_err_o),
        .active_f      (active_f)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        int unsigned idx;
        bit          v;
        bit          e;
        logic [7:0]  d;
    } ev_t;

    typedef struct {
        logic [7:0] data;
        bit         stop;
        int         gap;
        bit         exp_valid;
        logic [7:0] exp_data;
    } vec_t;

    ev_t         evq[$];
    int unsigned ncyc = 0;
    int          nvec = 0;
    int          nerr = 0;
    int unsigned act_rise = 0;
    int unsigned act_fall = 0;
    logic        prev_act = 1'b0;

    task automatic chk(input string nm, input longint act, input longint exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    always @(posedge clk_i) ncyc <= ncyc + 1;

    always @(negedge clk_i) begin
        if (valid_o || framing_err_o) begin
            ev_t ev;
            ev.idx = ncyc;
            ev.v   = valid_o;
            ev.e   = framing_err_o;
            ev.d   = data_o;
            evq.push_back(ev);
            chk("pulse exclusive", longint'(valid_o & framing_err_o), 0);
        end
        if (active_f && !prev_act) act_rise = ncyc;
        if (!active_f && prev_act) act_fall = ncyc;
        prev_act = active_f;
    end

    // Called on a negedge; the next posedge is E0 of the frame.
    task automatic send_frame(input logic [7:0] b, input bit stop, input int gap,
                              output int unsigned e0);
        rx_i = 1'b0;
        e0 = ncyc + 1;
        repeat (CPB) @(negedge clk_i);
        for (int i = 0; i < 8; i++) begin
            rx_i = b[i];
            repeat (CPB) @(negedge clk_i);
        end
        rx_i = stop;
        repeat (CPB) @(negedge clk_i);
        rx_i = 1'b1;
        repeat (gap) @(negedge clk_i);
    endtask

    task automatic check_event(input string nm, input int unsigned e0, input bit exp_v,
                               input logic [7:0] exp_d, output int unsigned ev_idx);
        ev_t ev;
        ev_idx = 0;
        chk({nm, " event count"}, evq.size(), 1);
        if (evq.size() > 0) begin
            ev = evq.pop_front();
            ev_idx = ev.idx;
            chk({nm, " latency"}, longint'(ev.idx) - longint'(e0), LAT);
            chk({nm, " valid"}, ev.v, exp_v);
            chk({nm, " framing_err"}, ev.e, !exp_v);
            chk({nm, " data at pulse"}, ev.d, exp_d);
        end
        chk({nm, " data_o"}, data_o, exp_d);
        evq.delete();
    endtask

    vec_t        tbl[4];
    int unsigned e0, ev_idx, prev_idx;
    logic [7:0]  last_good;

    initial begin
        tbl[0] = '{8'h55, 1'b1, 20, 1'b1, 8'h55};
        tbl[1] = '{8'hA3, 1'b1, 0,  1'b1, 8'hA3};
        tbl[2] = '{8'h0F, 1'b1, 10, 1'b1, 8'h0F};
        tbl[3] = '{8'hC4, 1'b0, 10, 1'b0, 8'h0F};

        reset_i = 1'b1;
        rx_i    = 1'b1;
        repeat (3) @(negedge clk_i);
        reset_i = 1'b0;
        chk("reset data_o", data_o, 8'h00);
        chk("reset valid_o", valid_o, 0);
        chk("reset framing_err_o", framing_err_o, 0);
        chk("reset active_f", active_f, 0);
        repeat (5) @(negedge clk_i);
        last_good = 8'h00;

        prev_idx = 0;
        for (int i = 0; i < 4; i++) begin
            send_frame(tbl[i].data, tbl[i].stop, tbl[i].gap, e0);
            check_event($sformatf("vec%0d", i), e0, tbl[i].exp_valid, tbl[i].exp_data, ev_idx);
            if (i == 0) begin
                chk("active rise", longint'(act_rise) - longint'(e0), 3);
                chk("active fall window",
                    ((act_fall - e0) >= LAT && (act_fall - e0) <= LAT + 1) ? 1 : 0, 1);
            end
            if (i == 2) chk("back-to-back spacing", longint'(ev_idx) - longint'(prev_idx), 160);
            prev_idx = ev_idx;
        end
        last_good = 8'h0F;

        // Glitch: three low cycles must not produce a frame.
        rx_i = 1'b0;
        e0 = ncyc + 1;
        repeat (3) @(negedge clk_i);
        rx_i = 1'b1;
        @(negedge clk_i);
        chk("glitch active", active_f, 1);
        repeat (40) @(negedge clk_i);
        chk("glitch events", evq.size(), 0);
        chk("glitch data_o", data_o, last_good);
        chk("glitch active end", active_f, 0);

        // Break: long low line gives exactly one framing error.
        rx_i = 1'b0;
        e0 = ncyc + 1;
        for (int i = 0; i < 400; i++) begin
            @(negedge clk_i);
            if (i == 299) chk("break active in cleanup", active_f, 0);
        end
        rx_i = 1'b1;
        repeat (30) @(negedge clk_i);
        check_event("break", e0, 1'b0, last_good, ev_idx);
        send_frame(8'h81, 1'b1, 10, e0);
        check_event("after break", e0, 1'b1, 8'h81, ev_idx);
        last_good = 8'h81;

        // Reset at E80 of a frame abandons it.
        fork
            send_frame(8'hFF, 1'b1, 20, e0);
            begin
                repeat (80) @(negedge clk_i);
                reset_i = 1'b1;
                @(negedge clk_i);
                reset_i = 1'b0;
                chk("midreset data_o", data_o, 8'h00);
                chk("midreset valid_o", valid_o, 0);
                chk("midreset framing_err_o", framing_err_o, 0);
                chk("midreset active_f", active_f, 0);
            end
        join
        chk("midreset events", evq.size(), 0);
        last_good = 8'h00;
        send_frame(8'h3C, 1'b1, 10, e0);
        check_event("after reset", e0, 1'b1, 8'h3C, ev_idx);
        last_good = 8'h3C;

        // Randomized frames against a frame-level model.
        for (int i = 0; i < 24; i++) begin
            logic [7:0] b;
            bit         st;
            int         gap;
            b   = 8'($urandom_range(0, 255));
            st  = ($urandom_range(0, 3) != 0);
            gap = st ? int'($urandom_range(0, 12)) : int'($urandom_range(5, 12));
            send_frame(b, st, gap, e0);
            if (st) last_good = b;
            check_event($sformatf("rand%0d", i), e0, st, last_good, ev_idx);
        end

        repeat (20) @(negedge clk_i);
        chk("no stray events", evq.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
